mtimer: RTL and testbench

- Memory-mapped machine timer and software-interrupt source for one hart; the producing end of the CSR unit's interrupt inputs.
- Holds 64-bit mtime and mtimecmp, plus a one-bit msip register.
- Drives the registered timer-interrupt-pending level (o_Int_tip) into the CSR unit's i_Int_tip, and the software-interrupt level (o_Int_sip).
- Sits on the data bus beside data memory, behind the core's address decoder.

---
 rtl/mtimer.sv | 126 ++++++++++++
 tb/tb_mtimer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer.sv
// rtl/mtimer.sv - memory-mapped machine timer and software interrupt source
//
// Holds the 64-bit mtime / mtimecmp pair and the msip bit for one hart.
// Bus accesses are accepted on every rising edge with i_req=1 and are
// answered with a single-cycle o_ack in the following cycle.
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous reset, active low
//   i_req      bus request, one-cycle pulse per access
//   i_we       1 = write, 0 = read (sampled with i_req)
//   i_addr     byte offset within the block (sampled with i_req)
//   i_wdata    write data (sampled with i_req)
//   o_ack      one-cycle response pulse
//   o_err      access error, valid with o_ack
//   o_rdata    read data, valid with o_ack, 0 otherwise
//   o_Int_tip  registered timer interrupt pending level
//   o_Int_sip  software interrupt pending level (msip)

module mtimer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_Int_tip,
  output logic        o_Int_sip
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [15:0] presc_q, presc_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tip_q, tip_d;

  logic        tick;
  logic        addr_ok;
  logic        wr;
  logic [31:0] rd_val;

  always_comb begin
    tick    = (presc_q == PS_LAST);
    addr_ok = (i_addr[1:0] == 2'b00) && (i_addr <= 5'h10);
    wr      = i_req && i_we && addr_ok;

    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;

    // An mtime write replaces the tick increment for that cycle: the
    // written half takes the new value and the other half holds.
    if (wr) begin
      case (i_addr[4:2])
        3'd0: mtimecmp_d = {mtimecmp_q[63:32], i_wdata};
        3'd1: mtimecmp_d = {i_wdata, mtimecmp_q[31:0]};
        3'd2: begin
          mtime_d = {mtime_q[63:32], i_wdata};
          presc_d = 16'd0;
        end
        3'd3: begin
          mtime_d = {i_wdata, mtime_q[31:0]};
          presc_d = 16'd0;
        end
        3'd4:    msip_d = i_wdata[0];
        default: ;
      endcase
    end

    // Read data is taken from the pre-edge register values.
    rd_val = 32'd0;
    case (i_addr[4:2])
      3'd0:    rd_val = mtimecmp_q[31:0];
      3'd1:    rd_val = mtimecmp_q[63:32];
      3'd2:    rd_val = mtime_q[31:0];
      3'd3:    rd_val = mtime_q[63:32];
      3'd4:    rd_val = {31'd0, msip_q};
      default: rd_val = 32'd0;
    endcase

    ack_d   = i_req;
    err_d   = i_req && !addr_ok;
    rdata_d = (i_req && !i_we && addr_ok) ? rd_val : 32'd0;
    tip_d   = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      presc_q    <= 16'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      tip_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      presc_q    <= presc_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      tip_q      <= tip_d;
    end
  end

  assign o_ack     = ack_q;
  assign o_err     = err_q;
  assign o_rdata   = rdata_q;
  assign o_Int_tip = tip_q;
  assign o_Int_sip = msip_q;

endmodule

// File: tb/tb_mtimer.sv
// tb/tb_mtimer.sv - directed self-checking bench for mtimer

module tb_mtimer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req;
  logic        i_we;
  logic [4:0]  i_addr;
  logic [31:0] i_wdata;

  logic        o_ack, o_err, o_Int_tip, o_Int_sip;
  logic [31:0] o_rdata;
  logic        o_ack4, o_err4, o_Int_tip4, o_Int_sip4;
  logic [31:0] o_rdata4;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 i_clk = ~i_clk;

  mtimer #(.PRESCALE(1)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_ack(o_ack), .o_err(o_err),
    .o_rdata(o_rdata), .o_Int_tip(o_Int_tip), .o_Int_sip(o_Int_sip)
  );

  mtimer #(.PRESCALE(4)) u_dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_ack(o_ack4), .o_err(o_err4),
    .o_rdata(o_rdata4), .o_Int_tip(o_Int_tip4), .o_Int_sip(o_Int_sip4)
  );

  // Drives one request for one edge; on return the response is visible.
  task automatic access(input logic we, input logic [4:0] addr, input logic [31:0] wdata);
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
    @(negedge i_clk);
    i_req = 1'b0; i_we = 1'b0;
  endtask

  task automatic test_reset();
    logic tip_seen;
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    total_cnt++;
    if ({o_ack, o_err, o_rdata, o_Int_tip, o_Int_sip} !== 36'd0)
      $display("FAIL reset_outputs got %h exp 0", {o_ack, o_err, o_rdata, o_Int_tip, o_Int_sip});
    else pass_cnt++;
    i_rst = 1'b1;
    tip_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_Int_tip !== 1'b0) tip_seen = 1'b1;
    end
    access(1'b0, 5'h08, 32'd0);
    total_cnt++;
    if (o_ack !== 1'b1 || o_rdata !== 32'd10)
      $display("FAIL reset_read_mtime got ack=%b %h exp ack=1 %h", o_ack, o_rdata, 32'd10);
    else pass_cnt++;
    access(1'b0, 5'h00, 32'd0);
    total_cnt++;
    if (o_rdata !== 32'hFFFF_FFFF)
      $display("FAIL reset_cmp_lo got %h exp ffffffff", o_rdata);
    else pass_cnt++;
    access(1'b0, 5'h04, 32'd0);
    total_cnt++;
    if (o_rdata !== 32'hFFFF_FFFF)
      $display("FAIL reset_cmp_hi got %h exp ffffffff", o_rdata);
    else pass_cnt++;
    if (o_Int_tip !== 1'b0) tip_seen = 1'b1;
    total_cnt++;
    if (tip_seen !== 1'b0)
      $display("FAIL reset_tip_low got %b exp 0", tip_seen);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    access(1'b1, 5'h08, 32'hFFFF_FFFE);
    access(1'b1, 5'h0C, 32'h0);
    repeat (3) @(negedge i_clk);
    access(1'b0, 5'h0C, 32'd0);
    total_cnt++;
    if (o_rdata !== 32'h1)
      $display("FAIL carry_hi got %h exp 00000001", o_rdata);
    else pass_cnt++;
    access(1'b0, 5'h08, 32'd0);
    total_cnt++;
    if (o_rdata !== 32'h2)
      $display("FAIL carry_lo got %h exp 00000002", o_rdata);
    else pass_cnt++;
    access(1'b1, 5'h0C, 32'hFFFF_FFFF);
    access(1'b1, 5'h08, 32'hFFFF_FFFF);
    access(1'b0, 5'h08, 32'd0);
    total_cnt++;
    if (o_rdata !== 32'hFFFF_FFFF || o_Int_tip !== 1'b1)
      $display("FAIL wrap_max got %h tip=%b exp ffffffff tip=1", o_rdata, o_Int_tip);
    else pass_cnt++;
    access(1'b0, 5'h0C, 32'd0);
    total_cnt++;
    if (o_rdata !== 32'h0 || o_Int_tip !== 1'b0)
      $display("FAIL wrap_hi got %h tip=%b exp 00000000 tip=0", o_rdata, o_Int_tip);
    else pass_cnt++;
    access(1'b0, 5'h08, 32'd0);
    total_cnt++;
    if (o_rdata !== 32'h1)
      $display("FAIL wrap_lo got %h exp 00000001", o_rdata);
    else pass_cnt++;
  endtask

  task automatic test_tip();
    logic tip_early;
    access(1'b1, 5'h04, 32'd0);
    access(1'b1, 5'h00, 32'd20);
    access(1'b1, 5'h08, 32'd0);
    tip_early = o_Int_tip;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_Int_tip !== 1'b0) tip_early = 1'b1;
    end
    total_cnt++;
    if (tip_early !== 1'b0)
      $display("FAIL tip_early got %b exp 0", tip_early);
    else pass_cnt++;
    @(negedge i_clk);
    total_cnt++;
    if (o_Int_tip !== 1'b1)
      $display("FAIL tip_rise got %b exp 1", o_Int_tip);
    else pass_cnt++;
    access(1'b1, 5'h04, 32'd1);
    total_cnt++;
    if (o_Int_tip !== 1'b1)
      $display("FAIL tip_lag got %b exp 1", o_Int_tip);
    else pass_cnt++;
    @(negedge i_clk);
    total_cnt++;
    if (o_Int_tip !== 1'b0)
      $display("FAIL tip_fall got %b exp 0", o_Int_tip);
    else pass_cnt++;
  endtask

  task automatic test_prescale();
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (8) @(negedge i_clk);
    access(1'b0, 5'h08, 32'd0);
    total_cnt++;
    if (o_rdata4 !== 32'd2)
      $display("FAIL ps_rate got %h exp %h", o_rdata4, 32'd2);
    else pass_cnt++;
    @(negedge i_clk);
    access(1'b1, 5'h08, 32'd100);
    repeat (2) @(negedge i_clk);
    access(1'b0, 5'h08, 32'd0);
    total_cnt++;
    if (o_rdata4 !== 32'd100)
      $display("FAIL ps_hold3 got %h exp %h", o_rdata4, 32'd100);
    else pass_cnt++;
    access(1'b0, 5'h08, 32'd0);
    total_cnt++;
    if (o_rdata4 !== 32'd100)
      $display("FAIL ps_hold4 got %h exp %h", o_rdata4, 32'd100);
    else pass_cnt++;
    access(1'b0, 5'h08, 32'd0);
    total_cnt++;
    if (o_rdata4 !== 32'd101)
      $display("FAIL ps_inc got %h exp %h", o_rdata4, 32'd101);
    else pass_cnt++;
    repeat (2) @(negedge i_clk);
    access(1'b1, 5'h0C, 32'd7);
    access(1'b0, 5'h08, 32'd0);
    total_cnt++;
    if (o_rdata4 !== 32'd101)
      $display("FAIL ps_write_tick_lo got %h exp %h", o_rdata4, 32'd101);
    else pass_cnt++;
    access(1'b0, 5'h0C, 32'd0);
    total_cnt++;
    if (o_rdata4 !== 32'd7)
      $display("FAIL ps_write_tick_hi got %h exp %h", o_rdata4, 32'd7);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    access(1'b0, 5'h02, 32'd0);
    total_cnt++;
    if ({o_ack, o_err, o_rdata} !== {2'b11, 32'd0})
      $display("FAIL err_rd02 got %h exp %h", {o_ack, o_err, o_rdata}, {2'b11, 32'd0});
    else pass_cnt++;
    access(1'b0, 5'h14, 32'd0);
    total_cnt++;
    if ({o_ack, o_err, o_rdata} !== {2'b11, 32'd0})
      $display("FAIL err_rd14 got %h exp %h", {o_ack, o_err, o_rdata}, {2'b11, 32'd0});
    else pass_cnt++;
    access(1'b1, 5'h1C, 32'd0);
    total_cnt++;
    if ({o_ack, o_err} !== 2'b11)
      $display("FAIL err_wr1c got %b exp 11", {o_ack, o_err});
    else pass_cnt++;
    access(1'b1, 5'h01, 32'd0);
    total_cnt++;
    if ({o_ack, o_err} !== 2'b11)
      $display("FAIL err_wr01 got %b exp 11", {o_ack, o_err});
    else pass_cnt++;
    access(1'b0, 5'h00, 32'd0);
    total_cnt++;
    if ({o_err, o_rdata} !== {1'b0, 32'hFFFF_FFFF})
      $display("FAIL err_no_effect got %h exp %h", {o_err, o_rdata}, {1'b0, 32'hFFFF_FFFF});
    else pass_cnt++;
    access(1'b1, 5'h10, 32'hFFFF_FFFF);
    total_cnt++;
    if (o_Int_sip !== 1'b1)
      $display("FAIL msip_set got %b exp 1", o_Int_sip);
    else pass_cnt++;
    access(1'b0, 5'h10, 32'd0);
    total_cnt++;
    if (o_rdata !== 32'h1)
      $display("FAIL msip_read got %h exp 00000001", o_rdata);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    i_req = 1'b1; i_we = 1'b0; i_addr = 5'h08;
    @(negedge i_clk);
    total_cnt++;
    if (o_ack !== 1'b1)
      $display("FAIL b2b_ack1 got %b exp 1", o_ack);
    else pass_cnt++;
    i_we = 1'b1; i_wdata = 32'd5;
    @(negedge i_clk);
    total_cnt++;
    if ({o_ack, o_err} !== 2'b10)
      $display("FAIL b2b_ack2 got %b exp 10", {o_ack, o_err});
    else pass_cnt++;
    i_we = 1'b0;
    @(negedge i_clk);
    total_cnt++;
    if (o_ack !== 1'b1 || o_rdata !== 32'd5)
      $display("FAIL b2b_read3 got ack=%b %h exp ack=1 %h", o_ack, o_rdata, 32'd5);
    else pass_cnt++;
    i_req = 1'b0;
    @(negedge i_clk);
    total_cnt++;
    if (o_ack !== 1'b0)
      $display("FAIL b2b_ack_drop got %b exp 0", o_ack);
    else pass_cnt++;

    access(1'b1, 5'h00, 32'd0);
    access(1'b1, 5'h04, 32'd0);
    @(negedge i_clk);
    total_cnt++;
    if ({o_Int_tip, o_Int_sip} !== 2'b11)
      $display("FAIL pre_reset_levels got %b exp 11", {o_Int_tip, o_Int_sip});
    else pass_cnt++;
    i_req = 1'b1; i_we = 1'b0; i_addr = 5'h08; i_rst = 1'b0;
    @(negedge i_clk);
    total_cnt++;
    if ({o_ack, o_err, o_rdata, o_Int_tip, o_Int_sip} !== 36'd0)
      $display("FAIL reset_in_flight got %h exp 0", {o_ack, o_err, o_rdata, o_Int_tip, o_Int_sip});
    else pass_cnt++;
    i_req = 1'b0;
    i_rst = 1'b1;
    access(1'b0, 5'h08, 32'd0);
    total_cnt++;
    if (o_ack !== 1'b1 || o_rdata !== 32'd0)
      $display("FAIL post_reset_mtime got ack=%b %h exp ack=1 0", o_ack, o_rdata);
    else pass_cnt++;
    access(1'b0, 5'h00, 32'd0);
    total_cnt++;
    if (o_rdata !== 32'hFFFF_FFFF)
      $display("FAIL post_reset_cmp got %h exp ffffffff", o_rdata);
    else pass_cnt++;
  endtask

  initial begin
    i_rst = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = 5'd0; i_wdata = 32'd0;
    @(negedge i_clk);
    test_reset();
    test_carry();
    test_tip();
    test_prescale();
    test_errors();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
